burst_rd_ctrl: RTL and testbench

Parametrised burst read controller. Accepts one burst request (address, beat count, beat size), fetches each beat from a single-beat device port, and returns the beats on a valid/ready response channel with per-beat byte enables and a last flag. It generalises the fixed 64-bit, 8-beat controller to any power-of-two data width, a programmable response buffer depth, and optional wrapping bursts. It sits between the request fabric and the device-side memory port.

---
 rtl/burst_rd_pkg.sv | 58 +++++
 rtl/burst_rd_ctrl_if.sv | 53 +++++
 rtl/burst_rd_fifo.sv | 60 ++++++
 rtl/burst_rd_ctrl.sv | 125 ++++++++++++
 tb/tb_burst_rd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_rd_pkg.sv
// Shared types and beat address / byte-enable helpers for burst_rd_ctrl.
// Wrap arithmetic is only exercised when BURST_WRAP_EN is defined.
package burst_rd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned BEN_LOG2 = $clog2(DEF_DATA_WIDTH / 8);
  localparam int unsigned MAX_BEN = 128;

  function automatic int unsigned eff_size(
    input int unsigned size,
    input int unsigned bl
  );
    return (size < bl) ? size : bl;
  endfunction

  function automatic logic [63:0] beat_addr(
    input logic [63:0] addr,
    input int unsigned size,
    input int unsigned beat,
    input logic        wrap,
    input int unsigned len,
    input int unsigned bl
  );
    int unsigned es;
    logic [63:0] aaddr;
    logic [63:0] inc;
    logic [63:0] wb;
    es    = eff_size(size, bl);
    aaddr = addr & ~((64'd1 << es) - 64'd1);
    inc   = aaddr + (64'(beat) << es);
    wb    = 64'(len + 1) << es;
    if (wrap)
      return (aaddr & ~(wb - 64'd1)) | (inc & (wb - 64'd1));
    return inc;
  endfunction

  function automatic logic [MAX_BEN-1:0] beat_ben(
    input logic [63:0] baddr,
    input int unsigned size,
    input int unsigned bl
  );
    int unsigned es;
    int unsigned off;
    logic [MAX_BEN-1:0] m;
    es  = eff_size(size, bl);
    m   = (es >= 7) ? '1
        : ((MAX_BEN'(1) << (1 << es)) - MAX_BEN'(1));
    off = 32'(baddr[6:0]) & ((32'd1 << bl) - 32'd1);
    return m << off;
  endfunction

endpackage

// File: rtl/burst_rd_ctrl_if.sv
// Request, device and response channels of burst_rd_ctrl.
// REQ_WRAP exists only when BURST_WRAP_EN is defined.
interface burst_rd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned SIZE_WIDTH = 3
);
  localparam int unsigned BEN_WIDTH = DATA_WIDTH / 8;

  logic                  REQ_VLD;
  logic                  REQ_RDY;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [LEN_WIDTH-1:0]  REQ_LEN;
  logic [SIZE_WIDTH-1:0] REQ_SIZE;
`ifdef BURST_WRAP_EN
  logic                  REQ_WRAP;
`endif
  logic                  DEV_REQ;
  logic                  DEV_ACK;
  logic [ADDR_WIDTH-1:0] DEV_ADDR;
  logic [DATA_WIDTH-1:0] DEV_DATA;
  logic                  RSP_VLD;
  logic                  RSP_RDY;
  logic [DATA_WIDTH-1:0] RSP_DATA;
  logic [BEN_WIDTH-1:0]  RSP_BEN;
  logic                  RSP_LAST;

  modport slave (
`ifdef BURST_WRAP_EN
    input  REQ_WRAP,
`endif
    input  REQ_VLD, REQ_ADDR, REQ_LEN, REQ_SIZE,
    output REQ_RDY,
    output DEV_REQ, DEV_ADDR,
    input  DEV_ACK, DEV_DATA,
    output RSP_VLD, RSP_DATA, RSP_BEN, RSP_LAST,
    input  RSP_RDY
  );

  modport master (
`ifdef BURST_WRAP_EN
    output REQ_WRAP,
`endif
    output REQ_VLD, REQ_ADDR, REQ_LEN, REQ_SIZE,
    input  REQ_RDY,
    input  DEV_REQ, DEV_ADDR,
    output DEV_ACK, DEV_DATA,
    input  RSP_VLD, RSP_DATA, RSP_BEN, RSP_LAST,
    output RSP_RDY
  );

endinterface

// File: rtl/burst_rd_fifo.sv
// Synchronous response buffer; power-of-two depth, head entry
// always visible on rdata.
module burst_rd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/burst_rd_ctrl.sv
// Burst read controller: one request in, single-beat device fetches,
// buffered beats out. Wrapping bursts need BURST_WRAP_EN.
module burst_rd_ctrl
  import burst_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned SIZE_WIDTH = 3,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             RESETn,
  burst_rd_ctrl_if.slave   bus
);
  localparam int unsigned BEN_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BL        = $clog2(BEN_WIDTH);
  localparam int unsigned FW        = DATA_WIDTH + BEN_WIDTH + 1;
  localparam int unsigned CW        = $clog2(BUF_DEPTH) + 1;

  state_e                state_q, state_d;
  logic                  req_rdy_q, req_rdy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_q, issue_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic                  wrap_q, wrap_d;

  logic [ADDR_WIDTH-1:0] baddr;
  logic [BEN_WIDTH-1:0]  ben;
  logic                  dev_req, push, pop, last, accept;
  logic                  full, empty, wrap_in;
  logic [CW-1:0]         count;
  logic [FW-1:0]         wdata, rdata;

`ifdef BURST_WRAP_EN
  logic [LEN_WIDTH:0] beats;
  assign beats   = {1'b0, bus.REQ_LEN} + 1'b1;
  // Non power-of-two beat counts fall back to incrementing.
  assign wrap_in = bus.REQ_WRAP && ((beats & (beats - 1'b1)) == '0);
`else
  assign wrap_in = 1'b0;
`endif

  always_comb begin
    baddr   = ADDR_WIDTH'(beat_addr(64'(addr_q), 32'(size_q),
                32'(issue_q), wrap_q, 32'(len_q), BL));
    ben     = BEN_WIDTH'(beat_ben(64'(baddr), 32'(size_q), BL));
    last    = (issue_q == len_q);
    dev_req = (state_q == S_FETCH) && (count < CW'(BUF_DEPTH));
    push    = dev_req && bus.DEV_ACK && !full;
    pop     = !empty && bus.RSP_RDY;
    accept  = req_rdy_q && bus.REQ_VLD;
    wdata   = {bus.DEV_DATA, ben, last};

    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    wrap_d  = wrap_q;
    issue_d = issue_q;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = bus.REQ_ADDR;
        len_d   = bus.REQ_LEN;
        size_d  = bus.REQ_SIZE;
        wrap_d  = wrap_in;
        issue_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: if (push) begin
        issue_d = issue_q + 1'b1;
        if (last)
          state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && rdata[0])
        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      req_rdy_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      wrap_q    <= 1'b0;
      issue_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_rdy_q <= req_rdy_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      wrap_q    <= wrap_d;
      issue_q   <= issue_d;
    end
  end

  burst_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.REQ_RDY  = req_rdy_q;
  assign bus.DEV_REQ  = dev_req;
  assign bus.DEV_ADDR = dev_req ? baddr : '0;
  assign bus.RSP_VLD  = !empty;
  assign {bus.RSP_DATA, bus.RSP_BEN, bus.RSP_LAST} =
    empty ? '0 : rdata;

endmodule

// File: tb/tb_burst_rd_ctrl.sv
// Randomized bench for burst_rd_ctrl against a queue-based beat model,
// plus directed bursts pinned to hand-computed values.
module tb_burst_rd_ctrl;

  logic clk;
  logic rst_n;

  burst_rd_ctrl_if #(
    .DATA_WIDTH (64), .ADDR_WIDTH (20),
    .LEN_WIDTH  (3),  .SIZE_WIDTH (3)
  ) bus ();

  burst_rd_ctrl #(
    .DATA_WIDTH (64), .ADDR_WIDTH (20), .LEN_WIDTH (3),
    .SIZE_WIDTH (3),  .BUF_DEPTH  (4)
  ) dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  ben;
    logic        last;
  } dbeat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ben;
    logic        last;
  } rbeat_t;

  dbeat_t exp_dev[$];
  rbeat_t exp_rsp[$];
  logic [19:0] log_addr[$];
  logic [7:0]  log_ben[$];
  logic        log_last[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int accept_cycle = 0;
  int first_vld = -1;
  bit ready_ok = 0;
  bit pend = 0;
  bit rand_en = 0;
  int ack_mode = 1;
  int rdy_mode = 1;
  logic [19:0] r_addr;
  logic [2:0]  r_len;
  logic [2:0]  r_size;
  logic        r_wrap;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h",
               nm, cycle, got, want);
    end
  endtask

  // Expected device beats straight from the address/enable rules.
  task automatic build(int unsigned addr, int unsigned len,
                       int unsigned size, bit wrap);
    int unsigned es, bytes, a, o, wb;
    dbeat_t b;
    es    = (size > 3) ? 3 : size;
    bytes = 1 << es;
    a     = addr - (addr % bytes);
    wb    = (len + 1) * bytes;
    for (int n = 0; n <= int'(len); n++) begin
      if (wrap)
        o = (a - (a % wb)) + ((a + n * bytes) % wb);
      else
        o = a + n * bytes;
      o = o % (1 << 20);
      b.addr = 20'(o);
      b.ben  = 8'(((1 << bytes) - 1) << (o % 8));
      b.last = (n == int'(len));
      exp_dev.push_back(b);
    end
  endtask

  function automatic bit model_idle();
    return exp_dev.size() == 0 && exp_rsp.size() == 0;
  endfunction

  task automatic step();
    logic [63:0] dd;
    bit idle, do_pop, do_ack, wrap_ok;
    rbeat_t r;
    @(posedge clk);
    if (rst_n) ready_ok = 1;
    #1;
    case (ack_mode)
      0: bus.DEV_ACK = ($urandom_range(0, 3) != 0);
      1: bus.DEV_ACK = 1'b1;
      default: bus.DEV_ACK = 1'b0;
    endcase
    dd = {$urandom, $urandom};
    bus.DEV_DATA = dd;
    case (rdy_mode)
      0: bus.RSP_RDY = ($urandom_range(0, 2) != 0);
      1: bus.RSP_RDY = 1'b1;
      2: bus.RSP_RDY = 1'b0;
      default: bus.RSP_RDY = !bus.RSP_RDY;
    endcase
    if (!pend && rand_en && $urandom_range(0, 2) == 0) begin
      r_addr = ($urandom_range(0, 7) == 0)
             ? 20'(20'hFFFC0 | $urandom_range(0, 63))
             : 20'($urandom);
      r_len  = 3'($urandom_range(0, 7));
      r_size = 3'($urandom_range(0, 7));
      r_wrap = 1'($urandom_range(0, 1));
      bus.REQ_VLD = 1'b1;
    end else begin
      bus.REQ_VLD = pend;
    end
    bus.REQ_ADDR = r_addr;
    bus.REQ_LEN  = r_len;
    bus.REQ_SIZE = r_size;
`ifdef BURST_WRAP_EN
    bus.REQ_WRAP = r_wrap;
`endif
    @(negedge clk);
    cycle++;
    idle = model_idle();
    chk("req_rdy", bus.REQ_RDY, ready_ok && idle);
    chk("dev_req", bus.DEV_REQ,
        exp_dev.size() > 0 && exp_rsp.size() < 4);
    if (bus.DEV_REQ && exp_dev.size() > 0)
      chk("dev_addr", bus.DEV_ADDR, exp_dev[0].addr);
    chk("rsp_vld", bus.RSP_VLD, exp_rsp.size() > 0);
    if (bus.RSP_VLD && exp_rsp.size() > 0) begin
      chk("rsp_data", bus.RSP_DATA, exp_rsp[0].data);
      chk("rsp_ben", bus.RSP_BEN, exp_rsp[0].ben);
      chk("rsp_last", bus.RSP_LAST, exp_rsp[0].last);
      if (first_vld < 0) first_vld = cycle;
    end
    do_pop = bus.RSP_VLD && bus.RSP_RDY && exp_rsp.size() > 0;
    do_ack = bus.DEV_REQ && bus.DEV_ACK && exp_dev.size() > 0;
    if (do_pop) begin
      log_ben.push_back(exp_rsp[0].ben);
      log_last.push_back(exp_rsp[0].last);
      void'(exp_rsp.pop_front());
    end
    if (do_ack) begin
      r.data = dd;
      r.ben  = exp_dev[0].ben;
      r.last = exp_dev[0].last;
      exp_rsp.push_back(r);
      log_addr.push_back(bus.DEV_ADDR);
      void'(exp_dev.pop_front());
    end
    if (bus.REQ_VLD && ready_ok && idle) begin
      wrap_ok = 0;
`ifdef BURST_WRAP_EN
      wrap_ok = r_wrap && ((r_len & (r_len + 3'd1)) == 3'd0);
`endif
      build(r_addr, r_len, r_size, wrap_ok);
      pend = 0;
      accept_cycle = cycle;
      first_vld = -1;
    end
  endtask

  task automatic run_drain(int max);
    bit done;
    done = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!pend && model_idle()) begin
        done = 1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic start(logic [19:0] a, logic [2:0] l,
                       logic [2:0] s, logic w);
    r_addr = a; r_len = l; r_size = s; r_wrap = w;
    pend = 1;
    log_addr.delete(); log_ben.delete(); log_last.delete();
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_req_rdy"}, bus.REQ_RDY, 0);
    chk({nm, "_dev_req"}, bus.DEV_REQ, 0);
    chk({nm, "_dev_addr"}, bus.DEV_ADDR, 0);
    chk({nm, "_rsp_vld"}, bus.RSP_VLD, 0);
    chk({nm, "_rsp_data"}, bus.RSP_DATA, 0);
    chk({nm, "_rsp_ben"}, bus.RSP_BEN, 0);
    chk({nm, "_rsp_last"}, bus.RSP_LAST, 0);
  endtask

  task automatic zero_inputs();
    bus.REQ_VLD = 0; bus.REQ_ADDR = 0; bus.REQ_LEN = 0;
    bus.REQ_SIZE = 0; bus.DEV_ACK = 0; bus.DEV_DATA = 0;
    bus.RSP_RDY = 0;
`ifdef BURST_WRAP_EN
    bus.REQ_WRAP = 0;
`endif
  endtask

  initial begin
    rst_n = 0;
    r_addr = 0; r_len = 0; r_size = 0; r_wrap = 0;
    zero_inputs();
    #3;
    check_zero("reset");
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    @(posedge clk);
    #1 rst_n = 1;

    // 0x13, 4 beats of 2 bytes, device and sink always ready
    ack_mode = 1; rdy_mode = 1;
    start(20'h13, 3'd3, 3'd1, 1'b0);
    run_drain(40);
    chk("t1_nbeats", log_addr.size(), 4);
    chk("t1_a0", log_addr[0], 20'h12);
    chk("t1_a1", log_addr[1], 20'h14);
    chk("t1_a2", log_addr[2], 20'h16);
    chk("t1_a3", log_addr[3], 20'h18);
    chk("t1_b0", log_ben[0], 8'h0C);
    chk("t1_b1", log_ben[1], 8'h30);
    chk("t1_b2", log_ben[2], 8'hC0);
    chk("t1_b3", log_ben[3], 8'h03);
    chk("t1_last", {log_last[0], log_last[1],
                    log_last[2], log_last[3]}, 4'b0001);
    chk("t1_latency", first_vld - accept_cycle, 2);

    // sink stalled: buffer fills to 4 and fetching stops
    rdy_mode = 2;
    start(20'h100, 3'd7, 3'd3, 1'b0);
    repeat (12) step();
    chk("t2_acks_full", log_addr.size(), 4);
    chk("t2_dev_req_low", bus.DEV_REQ, 0);
    rdy_mode = 1;
    run_drain(60);
    chk("t2_pops", log_ben.size(), 8);
    for (int n = 0; n < 8; n++)
      chk("t2_addr", log_addr[n], 20'h100 + 20'(n * 8));

    // sink ready toggling
    ack_mode = 0; rdy_mode = 3;
    start(20'h300, 3'd7, 3'd2, 1'b0);
    run_drain(120);
    chk("t3_pops", log_ben.size(), 8);
    for (int n = 0; n < 8; n++)
      chk("t3_ben", log_ben[n], (n % 2) ? 8'hF0 : 8'h0F);

    // oversize beat clamps to the bus width
    ack_mode = 1; rdy_mode = 1;
    start(20'h45, 3'd1, 3'd7, 1'b0);
    run_drain(40);
    chk("t4_a0", log_addr[0], 20'h40);
    chk("t4_a1", log_addr[1], 20'h48);
    chk("t4_b0", log_ben[0], 8'hFF);
    chk("t4_b1", log_ben[1], 8'hFF);

`ifdef BURST_WRAP_EN
    start(20'h38, 3'd3, 3'd3, 1'b1);
    run_drain(40);
    chk("t5_a0", log_addr[0], 20'h38);
    chk("t5_a1", log_addr[1], 20'h20);
    chk("t5_a2", log_addr[2], 20'h28);
    chk("t5_a3", log_addr[3], 20'h30);
`endif

    // random traffic
    ack_mode = 0; rdy_mode = 0; rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    run_drain(200);

    // reset in the middle of an 8-beat burst
    ack_mode = 1; rdy_mode = 2;
    start(20'h400, 3'd7, 3'd3, 1'b0);
    for (int i = 0; i < 20 && log_addr.size() < 2; i++) step();
    chk("t6_two_beats", log_addr.size(), 2);
    #2;
    rst_n = 0;
    zero_inputs();
    #1;
    check_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check_zero("mid_rst_hold");
    end
    exp_dev.delete(); exp_rsp.delete();
    pend = 0;
    @(posedge clk);
    #1 rst_n = 1;
    ready_ok = 0;
    rdy_mode = 1;
    step();
    chk("t6_rdy_after", bus.REQ_RDY, 1);
    chk("t6_no_stale", bus.RSP_VLD, 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
